// File: rtl/lock_key_loader.sv
// lock_key_loader: shifts in a serial key frame, checks even parity, then drives keyinput.
// Optional KEY_WRITE_ONCE_EN: once a key is valid, reloads are refused until RST.
module lock_key_loader #(
    parameter int KEY_W = 9,
    parameter int CNT_W = 4
) (
    input  logic             CK,
    input  logic             RST,
    input  logic             load_start,
    input  logic             key_sen,
    input  logic             key_sdi,
    output logic [KEY_W-1:0] keyinput,
    output logic             key_valid,
    output logic             busy,
    output logic             key_err
);
    typedef enum logic [2:0] {IDLE, SHIFT, CHECK, VALID, ERR} state_t;

    state_t           state_q;
    logic [KEY_W-1:0] shadow_q, shadow_d, key_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, valid_q, busy_q, err_q, reload;

    assign shadow_d = {shadow_q[KEY_W-2:0], key_sdi};
    assign cnt_d    = cnt_q + CNT_W'(1);
`ifdef KEY_WRITE_ONCE_EN
    assign reload = load_start && (state_q == IDLE || state_q == ERR);
`else
    assign reload = load_start && (state_q == IDLE || state_q == VALID || state_q == ERR);
`endif

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            shadow_q <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (reload) begin
            state_q  <= SHIFT;
            shadow_q <= '0;
            key_q    <= '0;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            busy_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                SHIFT: if (key_sen) begin
                    // the bit after KEY_W data bits is the parity bit
                    if (cnt_q == CNT_W'(KEY_W)) begin
                        par_q   <= key_sdi;
                        state_q <= CHECK;
                    end else begin
                        shadow_q <= shadow_d;
                        cnt_q    <= cnt_d;
                    end
                end
                CHECK: begin
                    busy_q <= 1'b0;
                    if (^{shadow_q, par_q}) begin
                        err_q   <= 1'b1;
                        state_q <= ERR;
                    end else begin
                        key_q   <= shadow_q;
                        valid_q <= 1'b1;
                        state_q <= VALID;
                    end
                end
                default: ;
            endcase
        end
    end

    assign keyinput  = key_q;
    assign key_valid = valid_q;
    assign busy      = busy_q;
    assign key_err   = err_q;
endmodule
